// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control from decode/execute, instruction memory
// port, and the IF/ID register outputs consumed by decode.
interface fetch_unit_if;
    logic        stall;
    logic        redirect;
    logic [15:0] redirectPC;
    logic        hlt;
    logic [15:0] iAddr;
    logic        iRdEn;
    logic [15:0] iData;
    logic [15:0] instr;
    logic        instrValid;
    logic [15:0] pcPlus1;
    logic        halted;

    modport master (
        input  stall, redirect, redirectPC, hlt, iData,
        output iAddr, iRdEn, instr, instrValid, pcPlus1, halted
    );

    modport slave (
        output stall, redirect, redirectPC, hlt, iData,
        input  iAddr, iRdEn, instr, instrValid, pcPlus1, halted
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction-memory address, IF/ID register.
// Optional performance counters enabled by macro FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0] fetchCnt,
    output logic [15:0] bubbleCnt,
`endif
    fetch_unit_if.master bus
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [15:0] pcp1_q, pcp1_d;
    logic        fetch_ev;
    logic        bubble_ev;

    // Next-state: redirect beats halt beats stall beats normal fetch
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        pcp1_d    = pcp1_q;
        fetch_ev  = 1'b0;
        bubble_ev = 1'b0;
        unique case (state_q)
            RUN: begin
                if (bus.redirect) begin
                    pc_d      = bus.redirectPC;
                    instr_d   = NOP_INSTR;
                    valid_d   = 1'b0;
                    bubble_ev = 1'b1;
                end else if (bus.hlt && valid_q) begin
                    state_d = HALTED;
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end else if (!bus.stall) begin
                    instr_d  = bus.iData;
                    valid_d  = 1'b1;
                    pcp1_d   = pc_q + 16'd1;
                    pc_d     = pc_q + 16'd1;
                    fetch_ev = 1'b1;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: state_d = RUN;
        endcase
    end

    // State, PC and IF/ID registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            pcp1_q  <= RESET_PC + 16'd1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            pcp1_q  <= pcp1_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fcnt_q, fcnt_d;
    logic [15:0] bcnt_q, bcnt_d;

    // Saturating counters; events only fire in RUN so they freeze in HALTED
    always_comb begin
        fcnt_d = fcnt_q;
        bcnt_d = bcnt_q;
        if (fetch_ev && fcnt_q != 16'hFFFF)
            fcnt_d = fcnt_q + 16'd1;
        if (bubble_ev && bcnt_q != 16'hFFFF)
            bcnt_d = bcnt_q + 16'd1;
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_q <= 16'h0000;
            bcnt_q <= 16'h0000;
        end else begin
            fcnt_q <= fcnt_d;
            bcnt_q <= bcnt_d;
        end
    end

    assign fetchCnt  = fcnt_q;
    assign bubbleCnt = bcnt_q;
`else
    logic unused_ev;
    assign unused_ev = fetch_ev ^ bubble_ev;
`endif

    assign bus.iAddr      = pc_q;
    assign bus.iRdEn      = (state_q == RUN);
    assign bus.halted     = (state_q == HALTED);
    assign bus.instr      = instr_q;
    assign bus.instrValid = valid_q;
    assign bus.pcPlus1    = pcp1_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural model compared each
// cycle, plus directed literal checks from the test plan.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   started = 0;

    always #5 clk = ~clk;

    fetch_unit_if ifa();
    fetch_unit_if ifb();

    function automatic logic [15:0] mem(input logic [15:0] a);
        return 16'h1000 + a;
    endfunction

    assign ifa.iData = mem(ifa.iAddr);
    assign ifb.iData = mem(ifb.iAddr);

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fcA, bcA, fcB, bcB;
`endif

    fetch_unit #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0000)) u_a (
        .clk(clk),
        .rst(rst),
`ifdef FETCH_PERF_CNT_EN
        .fetchCnt(fcA),
        .bubbleCnt(bcA),
`endif
        .bus(ifa)
    );

    fetch_unit #(.RESET_PC(16'hFFFE), .NOP_INSTR(16'h0000)) u_b (
        .clk(clk),
        .rst(rst),
`ifdef FETCH_PERF_CNT_EN
        .fetchCnt(fcB),
        .bubbleCnt(bcB),
`endif
        .bus(ifb)
    );

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
        logic        valid;
        logic [15:0] pcp1;
        logic        halt;
        logic [15:0] fc;
        logic [15:0] bc;
    } mst_t;

    mst_t ma, mb;

    function automatic mst_t rst_state(input logic [15:0] rpc);
        mst_t s;
        s.pc = rpc; s.instr = 16'h0000; s.valid = 1'b0;
        s.pcp1 = rpc + 16'd1; s.halt = 1'b0; s.fc = 0; s.bc = 0;
        return s;
    endfunction

    function automatic logic [15:0] sat(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // One cycle of the fetch rules: a halted stage never changes
    function automatic mst_t step(input mst_t s, input logic red,
                                  input logic [15:0] rpc,
                                  input logic h, input logic st);
        mst_t n = s;
        if (s.halt) return n;
        if (red) begin
            n.pc = rpc; n.instr = 16'h0000; n.valid = 1'b0;
            n.bc = sat(s.bc);
        end else if (h && s.valid) begin
            n.halt = 1'b1; n.instr = 16'h0000; n.valid = 1'b0;
        end else if (!st) begin
            n.instr = mem(s.pc); n.valid = 1'b1;
            n.pcp1 = s.pc + 16'd1; n.pc = s.pc + 16'd1;
            n.fc = sat(s.fc);
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on the same edge the DUT samples
    always @(posedge clk) begin
        if (rst) begin
            ma = rst_state(16'h0000);
            mb = rst_state(16'hFFFE);
        end else begin
            ma = step(ma, ifa.redirect, ifa.redirectPC, ifa.hlt, ifa.stall);
            mb = step(mb, ifb.redirect, ifb.redirectPC, ifb.hlt, ifb.stall);
        end
        started = 1;
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (started) begin
            chk("A.iAddr", ifa.iAddr, ma.pc);
            chk("A.iRdEn", {15'd0, ifa.iRdEn}, {15'd0, !ma.halt});
            chk("A.instr", ifa.instr, ma.instr);
            chk("A.valid", {15'd0, ifa.instrValid}, {15'd0, ma.valid});
            chk("A.pcPlus1", ifa.pcPlus1, ma.pcp1);
            chk("A.halted", {15'd0, ifa.halted}, {15'd0, ma.halt});
            chk("B.iAddr", ifb.iAddr, mb.pc);
            chk("B.instr", ifb.instr, mb.instr);
            chk("B.pcPlus1", ifb.pcPlus1, mb.pcp1);
`ifdef FETCH_PERF_CNT_EN
            chk("A.fetchCnt", fcA, ma.fc);
            chk("A.bubbleCnt", bcA, ma.bc);
            chk("B.fetchCnt", fcB, mb.fc);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ifa.stall = 0; ifa.redirect = 0; ifa.redirectPC = 0; ifa.hlt = 0;
        ifb.stall = 0; ifb.redirect = 0; ifb.redirectPC = 0; ifb.hlt = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;

        chk("L.rst.valid", {15'd0, ifa.instrValid}, 16'd0);
        chk("L.rst.iAddr", ifa.iAddr, 16'h0000);
        chk("L.rst.pcp1", ifa.pcPlus1, 16'h0001);
        chk("L.rst.halted", {15'd0, ifa.halted}, 16'd0);
        chk("L.B.iAddr0", ifb.iAddr, 16'hFFFE);

        tick();
        chk("L.run.i0", ifa.instr, 16'h1000);
        chk("L.run.p0", ifa.pcPlus1, 16'h0001);
        chk("L.run.v0", {15'd0, ifa.instrValid}, 16'd1);
        chk("L.B.iAddr1", ifb.iAddr, 16'hFFFF);
        tick();
        chk("L.run.i1", ifa.instr, 16'h1001);
        chk("L.run.p1", ifa.pcPlus1, 16'h0002);
        chk("L.B.iAddr2", ifb.iAddr, 16'h0000);
        chk("L.B.pcp1wrap", ifb.pcPlus1, 16'h0000);
        tick();
        chk("L.run.i2", ifa.instr, 16'h1002);
        chk("L.run.p2", ifa.pcPlus1, 16'h0003);
        tick();
        tick();
        chk("L.pc4.instr", ifa.instr, 16'h1004);

        ifa.stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("L.stall.instr", ifa.instr, 16'h1004);
            chk("L.stall.pcp1", ifa.pcPlus1, 16'h0005);
            chk("L.stall.iAddr", ifa.iAddr, 16'h0005);
        end
        ifa.stall = 0;
        tick();
        chk("L.resume.instr", ifa.instr, 16'h1005);
        chk("L.resume.iAddr", ifa.iAddr, 16'h0006);

        ifa.redirect = 1; ifa.redirectPC = 16'h0040;
        ifa.stall = 1; ifa.hlt = 1;
        tick();
        ifa.redirect = 0; ifa.stall = 0; ifa.hlt = 0;
        chk("L.redir.valid", {15'd0, ifa.instrValid}, 16'd0);
        chk("L.redir.iAddr", ifa.iAddr, 16'h0040);
        chk("L.redir.halted", {15'd0, ifa.halted}, 16'd0);
        tick();
        chk("L.redir.instr", ifa.instr, 16'h1040);
        chk("L.redir.pcp1", ifa.pcPlus1, 16'h0041);
`ifdef FETCH_PERF_CNT_EN
        chk("L.redir.bcnt", bcA, 16'h0001);
`endif

        ifa.hlt = 1;
        tick();
        ifa.hlt = 0;
        chk("L.halt.halted", {15'd0, ifa.halted}, 16'd1);
        chk("L.halt.iRdEn", {15'd0, ifa.iRdEn}, 16'd0);
        chk("L.halt.valid", {15'd0, ifa.instrValid}, 16'd0);
        chk("L.halt.iAddr", ifa.iAddr, 16'h0041);
        ifa.redirect = 1; ifa.redirectPC = 16'h0080;
        tick();
        ifa.redirect = 0;
        tick();
        chk("L.halt.redirIgn", ifa.iAddr, 16'h0041);
        chk("L.halt.stay", {15'd0, ifa.halted}, 16'd1);

        rst = 1;
        tick();
        rst = 0;
        chk("L.rst2.iAddr", ifa.iAddr, 16'h0000);
        chk("L.rst2.halted", {15'd0, ifa.halted}, 16'd0);
        chk("L.rst2.iRdEn", {15'd0, ifa.iRdEn}, 16'd1);

`ifdef FETCH_PERF_CNT_EN
        repeat (70000) tick();
        chk("L.fcnt.sat", fcA, 16'hFFFF);
`endif
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 16-bit pipelined core. It is the producer of the `instr` word consumed by the decode/control block. It owns the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register. It reacts to the control signals decode and execute send back: stall, branch/jump redirect, and halt.

## Interface
Parameters:
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `NOP_INSTR`, default 16'h0000: word injected into IF/ID for a bubble.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: hazard hold; freezes PC and IF/ID.
- `redirect` in 1: taken branch or jump resolved in execute.
- `redirectPC` in 16: target PC; valid when `redirect`=1.
- `hlt` in 1: decode reports HLT in IF/ID.
- `iAddr` out 16: instruction-memory word address (current PC).
- `iRdEn` out 1: instruction-memory read enable.
- `iData` in 16: instruction word at `iAddr`, combinational same-cycle.
- `instr` out 16: IF/ID instruction register.
- `instrValid` out 1: IF/ID holds a real instruction.
- `pcPlus1` out 16: IF/ID instruction's PC+1, used as the JAL link value.
- `halted` out 1: fetch is in HALTED.
- `fetchCnt` out 16: present only with FETCH_PERF_CNT_EN.
- `bubbleCnt` out 16: present only with FETCH_PERF_CNT_EN.

## Operation
- State machine with two states, RUN and HALTED. Reset enters RUN.
- Reset values:
  - PC=`RESET_PC`, `instr`=`NOP_INSTR`, `instrValid`=0.
  - `pcPlus1`=`RESET_PC`+1, `halted`=0, counters=0.
- `iAddr`=PC at all times.
- `iRdEn`=1 in RUN and 0 in HALTED.
- RUN priority, evaluated each edge:
  1. `redirect`=1:
     - PC<=`redirectPC`.
     - IF/ID<=bubble (`instr`=`NOP_INSTR`, `instrValid`=0).
     - Overrides both `stall` and `hlt`, since the HLT in ID is wrong-path.
  2. `hlt`=1 and `instrValid`=1:
     - Go to HALTED. PC holds. IF/ID<=bubble.
     - Taken whether or not `stall` is asserted.
  3. `stall`=1: PC, `instr`, `instrValid` and `pcPlus1` all hold.
  4. Otherwise:
     - `instr`<=`iData`, `instrValid`<=1.
     - `pcPlus1`<=PC+1.
     - PC<=PC+1.
- `hlt` with `instrValid`=0 is ignored.
- PC arithmetic is 16-bit modulo: 16'hFFFF+1 = 16'h0000. The same wrap applies to `pcPlus1`.
- HALTED:
  - PC, IF/ID and counters are frozen.
  - `halted`=1.
  - `redirect`, `stall` and `hlt` are ignored.
  - Only `rst` exits HALTED.
- `rst` asserted mid-operation, in any state and with any inputs, forces the reset values on that edge.

## Timing
- Fetch latency is one cycle: address at PC in cycle n gives `instr` valid in cycle n+1.
- First valid instruction appears in the second cycle after `rst` deasserts. The first cycle after reset shows the bubble.
- Redirect penalty is exactly one bubble cycle:
  - `redirect` sampled at edge k.
  - `iAddr`=`redirectPC` in cycle k+1.
  - Target instruction is in IF/ID after edge k+1.
- Halt:
  - `halted` rises the cycle after the edge that samples `hlt`.
  - `iRdEn` drops in the same cycle.
- Stall is a pure hold: N stall cycles add exactly N cycles, with no lost or duplicated fetch.

## Configuration
- Macro `FETCH_PERF_CNT_EN`.
- When defined, two 16-bit counters and their ports exist:
  - `fetchCnt` increments on every edge that loads a valid instruction into IF/ID.
  - `bubbleCnt` increments on every edge that loads a bubble due to `redirect`.
  - Both saturate at 16'hFFFF, clear on `rst`, and freeze in HALTED.
- When undefined, neither the counters nor their ports exist; all other behaviour is identical.

## Test plan
- Reset, then run free with memory[i]=16'h1000+i:
  - `instr` sequence 16'h1000, 16'h1001, 16'h1002 on consecutive cycles.
  - `pcPlus1` = 1, 2, 3.
  - `instrValid`=0 only in the first cycle.
- Stall for 3 cycles while IF/ID holds PC 4: `instr`, `pcPlus1` and `iAddr` are unchanged for 3 cycles, then fetch resumes at PC 5.
- `redirect`=1 with `redirectPC`=16'h0040, with `stall`=1 and `hlt`=1 in the same cycle:
  - Next cycle: bubble, and `iAddr`=16'h0040.
  - Following cycle: `instr`=memory[16'h0040].
  - With the macro: `bubbleCnt`=1.
- HLT reaches IF/ID and `hlt`=1:
  - Next cycle: `halted`=1, `iRdEn`=0, `instrValid`=0, PC frozen.
  - A later `redirect` has no effect.
  - `rst` restores PC=16'h0000.
- With `RESET_PC`=16'hFFFE, run freely: `iAddr` goes 16'hFFFE, 16'hFFFF, 16'h0000, and `pcPlus1` wraps to 16'h0000.
- With the macro, after 70000 valid fetches: `fetchCnt`=16'hFFFF, saturated.
